adc_i2s_rx: RTL

Serial audio receiver for the codec ADC path, the capture-side counterpart of the DAC serialiser that feeds the voice mix to the codec. It synchronises AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT into the CLOCK_50 domain and deserialises I2S or left-justified frames into parallel left and right samples. Each completed stereo pair is presented on a valid/ack handshake to downstream consumers such as an input mixer or a level meter.

---
 rtl/synth_pkg.sv | 17 +
 rtl/sync_edge.sv | 35 +++
 rtl/adc_i2s_rx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the codec audio serial blocks.
package synth_pkg;

  localparam int AUDIO_W = 16;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_t;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for one asynchronous codec pin, followed by a third stage
// that provides registered rise/fall pulses aligned with the synchronised level.
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q, rise_q, fall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  end

  // Level taken from stage 3 so it lines up with the registered edge pulses.
  assign q_o    = s3_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/adc_i2s_rx.sv
// Codec ADC serial receiver: deserialises I2S / left-justified frames into
// left/right words and hands each stereo pair over on a valid/ack handshake.
//
// state | meaning
// SYNC  | waiting for the first LRCK fall; nothing captured
// SKIP  | after an LRCK edge, dropping I2S_DELAY bit-clock rises
// SHIFT | shifting in data bits of the current channel
module adc_i2s_rx
  import synth_pkg::*;
#(
  parameter int DATA_W    = AUDIO_W,
  parameter int I2S_DELAY = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              AUD_BCLK,
  input  logic              AUD_ADCLRCK,
  input  logic              AUD_ADCDAT,
  output logic [DATA_W-1:0] LDATA_IN,
  output logic [DATA_W-1:0] RDATA_IN,
  output logic              sample_valid,
  input  logic              sample_ack,
  output logic              overrun,
  output logic              short_frame,
  input  logic              clr_status
);

  localparam int                CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DATA_W);
  localparam logic [7:0]        SKIP_LAST = (I2S_DELAY > 0) ? 8'(I2S_DELAY - 1) : 8'd0;
  localparam rx_state_t         ENTRY_ST  = (I2S_DELAY > 0) ? SKIP : SHIFT;

  logic bclk_rise, lr_rise, lr_fall, dat_s;
  logic bclk_lvl_unused, bclk_fall_unused, lr_lvl_unused, dat_rise_unused, dat_fall_unused;

  sync_edge u_sync_bclk (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .d_i    (AUD_BCLK),
    .q_o    (bclk_lvl_unused),
    .rise_o (bclk_rise),
    .fall_o (bclk_fall_unused)
  );

  sync_edge u_sync_lrck (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .d_i    (AUD_ADCLRCK),
    .q_o    (lr_lvl_unused),
    .rise_o (lr_rise),
    .fall_o (lr_fall)
  );

  sync_edge u_sync_dat (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .d_i    (AUD_ADCDAT),
    .q_o    (dat_s),
    .rise_o (dat_rise_unused),
    .fall_o (dat_fall_unused)
  );

  rx_state_t         state_q, state_d;
  chan_t             chan_q, chan_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]        skip_cnt_q, skip_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] lhold_q, lhold_d;
  logic [DATA_W-1:0] ldata_q, ldata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              short_q, short_d;

  logic [DATA_W-1:0] word_aligned;
  logic              short_now;
  logic              commit_pair, set_short, set_ovr;

  // Bits arrive at the LSB, so a short word is shifted up to restore MSB alignment.
  assign word_aligned = shreg_q << (CNT_FULL - bit_cnt_q);
  assign short_now    = (bit_cnt_q < CNT_FULL);

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    bit_cnt_d   = bit_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    shreg_d     = shreg_q;
    lhold_d     = lhold_q;
    ldata_d     = ldata_q;
    rdata_d     = rdata_q;
    valid_d     = valid_q;
    commit_pair = 1'b0;
    set_short   = 1'b0;
    set_ovr     = 1'b0;

    case (state_q)
      SYNC: begin
        if (lr_fall) begin
          state_d    = ENTRY_ST;
          chan_d     = LEFT;
          bit_cnt_d  = '0;
          skip_cnt_d = '0;
          shreg_d    = '0;
        end
      end
      SKIP, SHIFT: begin
        if (lr_rise || lr_fall) begin
          set_short = short_now;
          if (lr_rise) begin
            lhold_d = word_aligned;
            chan_d  = RIGHT;
          end else begin
            ldata_d     = lhold_q;
            rdata_d     = word_aligned;
            commit_pair = 1'b1;
            chan_d      = LEFT;
          end
          state_d    = ENTRY_ST;
          bit_cnt_d  = '0;
          skip_cnt_d = '0;
          shreg_d    = '0;
        end else if (bclk_rise) begin
          if (state_q == SKIP) begin
            if (skip_cnt_q == SKIP_LAST) state_d = SHIFT;
            else                         skip_cnt_d = skip_cnt_q + 8'd1;
          end else if (short_now) begin
            shreg_d   = DATA_W'({shreg_q, dat_s});
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = SYNC;
    endcase

    if (valid_q && sample_ack) valid_d = 1'b0;
    if (commit_pair) begin
      valid_d = 1'b1;
      set_ovr = valid_q && !sample_ack;
    end

    overrun_d = (clr_status ? 1'b0 : overrun_q) | set_ovr;
    short_d   = (clr_status ? 1'b0 : short_q) | set_short;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= SYNC;
      chan_q     <= LEFT;
      bit_cnt_q  <= '0;
      skip_cnt_q <= '0;
      shreg_q    <= '0;
      lhold_q    <= '0;
      ldata_q    <= '0;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      bit_cnt_q  <= bit_cnt_d;
      skip_cnt_q <= skip_cnt_d;
      shreg_q    <= shreg_d;
      lhold_q    <= lhold_d;
      ldata_q    <= ldata_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      short_q    <= short_d;
    end
  end

  assign LDATA_IN     = ldata_q;
  assign RDATA_IN     = rdata_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign short_frame  = short_q;

endmodule
